// File: rtl/tawas_pkg.sv
// Shared types and sizes for the Tawas barrel core register file.
package tawas_pkg;

    localparam int SLICE_W    = 2;
    localparam int NUM_SLICES = 4;
    localparam int REG_SEL_W  = 3;
    localparam int NUM_REGS   = 8;
    localparam int NUM_RD     = 4;

    typedef logic [31:0] tawas_reg_t;

endpackage

// File: rtl/tawas_rf_bank.sv
// One slice's 8 x 32 register bank: three prioritised write ports, four read ports.
// Optional per-entry even parity when TAWAS_RF_PARITY_EN is defined.
module tawas_rf_bank
    import tawas_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_ld_en,
    input  logic [REG_SEL_W-1:0]              i_ld_sel,
    input  tawas_reg_t                        i_ld_data,
    input  logic                              i_au_en,
    input  logic [REG_SEL_W-1:0]              i_au_sel,
    input  tawas_reg_t                        i_au_data,
    input  logic                              i_pu_en,
    input  logic [REG_SEL_W-1:0]              i_pu_sel,
    input  tawas_reg_t                        i_pu_data,
    input  logic [NUM_RD-1:0][REG_SEL_W-1:0]  i_rd_sel,
`ifdef TAWAS_RF_PARITY_EN
    output logic [NUM_RD-1:0]                 o_rd_perr,
`endif
    output tawas_reg_t [NUM_RD-1:0]           o_rd_data
);

    tawas_reg_t [NUM_REGS-1:0] w_mem;
`ifdef TAWAS_RF_PARITY_EN
    logic [NUM_REGS-1:0]       w_par;
`endif

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        logic       w_we;
        tawas_reg_t w_wd;
        tawas_reg_t r_q;

        // Load data beats AU result beats pointer update on a same-register clash.
        always_comb begin
            w_we = 1'b1;
            w_wd = i_ld_data;
            if (i_ld_en && i_ld_sel == REG_SEL_W'(g))
                w_wd = i_ld_data;
            else if (i_au_en && i_au_sel == REG_SEL_W'(g))
                w_wd = i_au_data;
            else if (i_pu_en && i_pu_sel == REG_SEL_W'(g))
                w_wd = i_pu_data;
            else
                w_we = 1'b0;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_q <= '0;
            else if (w_we)
                r_q <= w_wd;
        end
        assign w_mem[g] = r_q;

`ifdef TAWAS_RF_PARITY_EN
        logic r_p;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_p <= 1'b0;
            else if (w_we)
                r_p <= ^w_wd;
        end
        assign w_par[g] = r_p;
`endif
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        assign o_rd_data[p] = w_mem[i_rd_sel[p]];
`ifdef TAWAS_RF_PARITY_EN
        assign o_rd_perr[p] = (^w_mem[i_rd_sel[p]]) ^ w_par[i_rd_sel[p]];
`endif
    end

endmodule

// File: rtl/tawas_regfile.sv
// Four-slice register file with slice-tag pipes that steer delayed AU/LS write-backs
// to the issuing slice's bank. Parity checking enabled by TAWAS_RF_PARITY_EN.
module tawas_regfile
    import tawas_pkg::*;
#(
    parameter int AU_WB_LAT = 2,
    parameter int LS_WB_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SLICE_W-1:0]   slice,
    input  logic [REG_SEL_W-1:0] au_ra_sel,
    output logic [31:0]          au_ra,
    input  logic [REG_SEL_W-1:0] au_rb_sel,
    output logic [31:0]          au_rb,
    input  logic                 au_rc_vld,
    input  logic [REG_SEL_W-1:0] au_rc_sel,
    input  logic [31:0]          au_rc,
    input  logic [REG_SEL_W-1:0] ls_ptr_sel,
    output logic [31:0]          ls_ptr,
    input  logic [REG_SEL_W-1:0] ls_store_sel,
    output logic [31:0]          ls_store,
    input  logic                 ls_ptr_upd_vld,
    input  logic [REG_SEL_W-1:0] ls_ptr_upd_sel,
    input  logic [31:0]          ls_ptr_upd,
    input  logic                 ls_load_vld,
    input  logic [REG_SEL_W-1:0] ls_load_sel,
    input  logic [31:0]          ls_load,
    output logic                 rf_parity_err,
    output logic [SLICE_W-1:0]   rf_parity_err_slice
);

    if (AU_WB_LAT < 1 || AU_WB_LAT > 3) begin : g_bad_au
        $error("tawas_regfile: AU_WB_LAT must be 1..3");
    end
    if (LS_WB_LAT < 1 || LS_WB_LAT > 3) begin : g_bad_ls
        $error("tawas_regfile: LS_WB_LAT must be 1..3");
    end

    // Captured slice history; the tail names the bank a returning result belongs to.
    logic [AU_WB_LAT-1:0][SLICE_W-1:0] r_au_tag;
    logic [LS_WB_LAT-1:0][SLICE_W-1:0] r_ls_tag;
    logic [SLICE_W-1:0]                w_au_wb_slice;
    logic [SLICE_W-1:0]                w_ls_wb_slice;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_au_tag <= '0;
            r_ls_tag <= '0;
        end else begin
            r_au_tag[0] <= slice;
            r_ls_tag[0] <= slice;
            for (int i = 1; i < AU_WB_LAT; i++) r_au_tag[i] <= r_au_tag[i-1];
            for (int i = 1; i < LS_WB_LAT; i++) r_ls_tag[i] <= r_ls_tag[i-1];
        end
    end

    assign w_au_wb_slice = r_au_tag[AU_WB_LAT-1];
    assign w_ls_wb_slice = r_ls_tag[LS_WB_LAT-1];

    logic [NUM_RD-1:0][REG_SEL_W-1:0]          w_rd_sel;
    tawas_reg_t [NUM_SLICES-1:0][NUM_RD-1:0]   w_rd;
`ifdef TAWAS_RF_PARITY_EN
    logic [NUM_SLICES-1:0][NUM_RD-1:0]         w_perr;
`endif

    assign w_rd_sel = {ls_store_sel, ls_ptr_sel, au_rb_sel, au_ra_sel};

    for (genvar b = 0; b < NUM_SLICES; b++) begin : g_bank
        tawas_rf_bank u_bank (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_ld_en   (ls_load_vld    && w_ls_wb_slice == SLICE_W'(b)),
            .i_ld_sel  (ls_load_sel),
            .i_ld_data (ls_load),
            .i_au_en   (au_rc_vld      && w_au_wb_slice == SLICE_W'(b)),
            .i_au_sel  (au_rc_sel),
            .i_au_data (au_rc),
            .i_pu_en   (ls_ptr_upd_vld && w_ls_wb_slice == SLICE_W'(b)),
            .i_pu_sel  (ls_ptr_upd_sel),
            .i_pu_data (ls_ptr_upd),
            .i_rd_sel  (w_rd_sel),
`ifdef TAWAS_RF_PARITY_EN
            .o_rd_perr (w_perr[b]),
`endif
            .o_rd_data (w_rd[b])
        );
    end

    assign au_ra    = w_rd[slice][0];
    assign au_rb    = w_rd[slice][1];
    assign ls_ptr   = w_rd[slice][2];
    assign ls_store = w_rd[slice][3];

`ifdef TAWAS_RF_PARITY_EN
    logic               r_perr;
    logic [SLICE_W-1:0] r_perr_slice;
    logic               w_perr_any;

    assign w_perr_any = |w_perr[slice];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perr       <= 1'b0;
            r_perr_slice <= '0;
        end else begin
            r_perr       <= w_perr_any;
            r_perr_slice <= w_perr_any ? slice : '0;
        end
    end

    assign rf_parity_err       = r_perr;
    assign rf_parity_err_slice = r_perr_slice;
`else
    assign rf_parity_err       = 1'b0;
    assign rf_parity_err_slice = '0;
`endif

endmodule

// File: tb/tb_tawas_regfile.sv
// Scoreboard bench for tawas_regfile: directed reads push expectations, a negedge monitor checks.
module tb_tawas_regfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  slice = '0;
    logic [2:0]  au_ra_sel = '0, au_rb_sel = '0, au_rc_sel = '0;
    logic [2:0]  ls_ptr_sel = '0, ls_store_sel = '0, ls_ptr_upd_sel = '0, ls_load_sel = '0;
    logic [31:0] au_ra, au_rb, ls_ptr, ls_store;
    logic        au_rc_vld = 1'b0, ls_ptr_upd_vld = 1'b0, ls_load_vld = 1'b0;
    logic [31:0] au_rc = '0, ls_ptr_upd = '0, ls_load = '0;
    logic        rf_parity_err;
    logic [1:0]  rf_parity_err_slice;

    always #5 clk = ~clk;

    tawas_regfile #(.AU_WB_LAT(2), .LS_WB_LAT(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .slice(slice),
        .au_ra_sel(au_ra_sel), .au_ra(au_ra), .au_rb_sel(au_rb_sel), .au_rb(au_rb),
        .au_rc_vld(au_rc_vld), .au_rc_sel(au_rc_sel), .au_rc(au_rc),
        .ls_ptr_sel(ls_ptr_sel), .ls_ptr(ls_ptr), .ls_store_sel(ls_store_sel), .ls_store(ls_store),
        .ls_ptr_upd_vld(ls_ptr_upd_vld), .ls_ptr_upd_sel(ls_ptr_upd_sel), .ls_ptr_upd(ls_ptr_upd),
        .ls_load_vld(ls_load_vld), .ls_load_sel(ls_load_sel), .ls_load(ls_load),
        .rf_parity_err(rf_parity_err), .rf_parity_err_slice(rf_parity_err_slice)
    );

    typedef struct {
        logic [1:0]  s;
        logic [2:0]  r;
        logic [31:0] data;
        logic        perr;
        logic [1:0]  perr_s;
    } exp_t;

    exp_t q[$];
    logic chk_vld = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_vld) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got empty queue want entry");
            end else begin
                exp_t e;
                string n;
                e = q.pop_front();
                n = $sformatf("s%0d_r%0d", e.s, e.r);
                cmp({n, "_au_ra"},    au_ra,    e.data);
                cmp({n, "_au_rb"},    au_rb,    e.data);
                cmp({n, "_ls_ptr"},   ls_ptr,   e.data);
                cmp({n, "_ls_store"}, ls_store, e.data);
                cmp({n, "_perr"},     {31'd0, rf_parity_err}, {31'd0, e.perr});
                cmp({n, "_perr_slice"}, {30'd0, rf_parity_err_slice}, {30'd0, e.perr_s});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] s, input logic [2:0] r, input logic [31:0] d,
                      input logic pe = 1'b0, input logic [1:0] ps = 2'd0);
        exp_t e;
        slice = s;
        au_ra_sel = r; au_rb_sel = r; ls_ptr_sel = r; ls_store_sel = r;
        e.s = s; e.r = r; e.data = d; e.perr = pe; e.perr_s = ps;
        q.push_back(e);
        chk_vld = 1'b1;
        cyc();
        chk_vld = 1'b0;
    endtask

    task automatic hold(input logic [1:0] s, input int n);
        slice = s;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic clr_wr();
        au_rc_vld = 1'b0; ls_ptr_upd_vld = 1'b0; ls_load_vld = 1'b0;
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        hold(2'd0, 3);
        rst_n = 1'b1;
        cyc();

        // reset: every register of every slice reads zero
        for (int s = 0; s < 4; s++)
            for (int r = 0; r < 8; r++)
                rd(2'(s), 3'(r), 32'h0);

        // AU write-back issued while slice 3 reads lands in slice 1 (two cycles earlier)
        hold(2'd0, 1); hold(2'd1, 1); hold(2'd2, 1);
        slice = 2'd3; au_rc_vld = 1'b1; au_rc_sel = 3'd5; au_rc = 32'hDEADBEEF;
        cyc();
        clr_wr();
        rd(2'd1, 3'd5, 32'hDEADBEEF);
        rd(2'd0, 3'd5, 32'h0);
        rd(2'd2, 3'd5, 32'h0);
        rd(2'd3, 3'd5, 32'h0);

        // same-register clash: load wins
        hold(2'd2, 4);
        ls_load_vld = 1'b1;    ls_load_sel = 3'd3;    ls_load = 32'h11;
        au_rc_vld = 1'b1;      au_rc_sel = 3'd3;      au_rc = 32'h22;
        ls_ptr_upd_vld = 1'b1; ls_ptr_upd_sel = 3'd3; ls_ptr_upd = 32'h33;
        cyc();
        clr_wr();
        rd(2'd2, 3'd3, 32'h11);

        // AU over pointer update when load targets another register
        hold(2'd2, 4);
        au_rc_vld = 1'b1;      au_rc_sel = 3'd4;      au_rc = 32'h22;
        ls_ptr_upd_vld = 1'b1; ls_ptr_upd_sel = 3'd4; ls_ptr_upd = 32'h33;
        cyc();
        clr_wr();
        rd(2'd2, 3'd4, 32'h22);

        // distinct registers in one cycle both land
        hold(2'd0, 4);
        ls_load_vld = 1'b1;    ls_load_sel = 3'd1;    ls_load = 32'hA5A5A5A5;
        ls_ptr_upd_vld = 1'b1; ls_ptr_upd_sel = 3'd2; ls_ptr_upd = 32'h00001004;
        cyc();
        clr_wr();
        rd(2'd0, 3'd1, 32'hA5A5A5A5);
        rd(2'd0, 3'd2, 32'h00001004);

        // mid-operation reset clears state and tags; first strobe after release hits bank 0
        hold(2'd3, 3);
        au_rc_vld = 1'b1; au_rc_sel = 3'd6; au_rc = 32'h12345678;
        cyc();
        rst_n = 1'b0; slice = 2'd2;
        cyc();
        rst_n = 1'b1; slice = 2'd2;
        au_rc_vld = 1'b1; au_rc_sel = 3'd6; au_rc = 32'hCAFEF00D;
        cyc();
        clr_wr();
        rd(2'd0, 3'd6, 32'hCAFEF00D);
        rd(2'd3, 3'd6, 32'h0);
        rd(2'd2, 3'd6, 32'h0);
        rd(2'd1, 3'd5, 32'h0);
        rd(2'd2, 3'd3, 32'h0);
        rd(2'd0, 3'd1, 32'h0);

`ifdef TAWAS_RF_PARITY_EN
        begin
            logic [7:0] pv;
            pv = {u_dut.g_bank[1].u_bank.g_reg[7].r_p, 7'd0};
            force u_dut.g_bank[1].u_bank.g_reg[7].r_p = ~pv[7];
            rd(2'd1, 3'd7, 32'h0);
            rd(2'd1, 3'd0, 32'h0, 1'b1, 2'd1);
            rd(2'd1, 3'd0, 32'h0);
            release u_dut.g_bank[1].u_bank.g_reg[7].r_p;
        end
`else
        rd(2'd1, 3'd7, 32'h0);
        rd(2'd1, 3'd0, 32'h0);
`endif

        cyc();
        cmp("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tawas_regfile.md
# tawas_regfile

Per-slice general register file for the Tawas barrel core. It sits directly upstream of the arithmetic unit and the load/store unit and supplies their operand reads. It also takes their delayed write-backs and lands each one in the bank of the slice that issued it. Four slices each own 8 × 32-bit registers. Slice tagging is done internally, so neither execution unit carries a slice ID with its result.

## Interface
Parameters:
- AU_WB_LAT, 2: cycles from AU operand read to `au_rc_vld`. Legal range 1..3; any other value is an elaboration error.
- LS_WB_LAT, 3: cycles from LS operand read to `ls_load_vld` / `ls_ptr_upd_vld`. Legal range 1..3.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- slice  in  2  slice currently in the read stage
- au_ra_sel  in  3  AU operand A register select
- au_ra  out  32  AU operand A
- au_rb_sel  in  3  AU operand B register select
- au_rb  out  32  AU operand B
- au_rc_vld  in  1  AU write-back strobe
- au_rc_sel  in  3  AU write-back register
- au_rc  in  32  AU write-back data
- ls_ptr_sel  in  3  LS pointer register select
- ls_ptr  out  32  LS pointer value
- ls_store_sel  in  3  LS store-data register select
- ls_store  out  32  LS store data
- ls_ptr_upd_vld  in  1  LS pointer post-increment write strobe
- ls_ptr_upd_sel  in  3  register for the pointer update
- ls_ptr_upd  in  32  updated pointer value
- ls_load_vld  in  1  LS load-data write strobe
- ls_load_sel  in  3  register for the load data
- ls_load  in  32  load data
- rf_parity_err  out  1  parity error pulse (only with `TAWAS_RF_PARITY_EN`)
- rf_parity_err_slice  out  2  slice whose read failed parity

## Operation
**Storage**
- 4 banks × 8 registers × 32 bits.
- Reset clears every register to 0, and clears all tag pipelines and error outputs.

**Reads**
- Four independent read ports.
- Purely combinational from bank[`slice`], indexed by each port's `*_sel`.

**Slice tag pipelines**
- Two shift registers capture `slice` every cycle.
- AU tag pipe: AU_WB_LAT deep. Its tail is `au_wb_slice`.
- LS tag pipe: LS_WB_LAT deep. Its tail is `ls_wb_slice`.
- Tags are captured values, not arithmetic on `slice`, so an irregular slice sequence is still tracked correctly.

**Writes**
- `au_rc_vld` writes `au_rc` into bank[`au_wb_slice`][`au_rc_sel`].
- `ls_ptr_upd_vld` writes `ls_ptr_upd` into bank[`ls_wb_slice`][`ls_ptr_upd_sel`].
- `ls_load_vld` writes `ls_load` into bank[`ls_wb_slice`][`ls_load_sel`].
- Writes to distinct (bank, reg) pairs in the same cycle all take effect.
- When several writes target the same (bank, reg) in one cycle, priority is: `ls_load` > `au_rc` > `ls_ptr_upd`. Only the winner is stored.

**Read/write collision**
- A read of a (bank, reg) being written in the same cycle returns the old value. There is no bypass.
- With legal latencies the read bank differs from the write bank under normal slice rotation, so this case does not arise in practice.

## Timing
- Read latency is 0 cycles: outputs are valid in the same cycle as `slice` and `*_sel`.
- A write is stored at the clock edge where its strobe is high, and is visible to reads from the next cycle.
- Tag pipes hold their reset value (slice 0) for the first AU_WB_LAT / LS_WB_LAT cycles after reset. Strobes during that window are legal and write to bank 0.
- `rst_n` asserted mid-operation discards all in-flight tags and registers immediately. There is no partial-write state.
- `rf_parity_err` is registered:
  - It asserts 1 cycle after the failing read and stays high for one cycle per failing cycle.
  - `rf_parity_err_slice` carries the read-cycle `slice`.
  - Reset value of both outputs is 0.

## Configuration
- `TAWAS_RF_PARITY_EN` defined:
  - Each register stores an extra even-parity bit, computed on write.
  - All four read ports are checked every cycle; any mismatch raises `rf_parity_err`.
  - Read data is returned unmodified.
- `TAWAS_RF_PARITY_EN` undefined:
  - No parity storage.
  - `rf_parity_err` and `rf_parity_err_slice` are tied to 0.

## Structure
- Shared package `tawas_pkg` holds:
  - `SLICE_W` = 2, `NUM_SLICES` = 4, `REG_SEL_W` = 3, `NUM_REGS` = 8
  - `tawas_reg_t` (32-bit word typedef)
- Sub-module `tawas_rf_bank`, instantiated four times:
  - one 8 × 32 bank
  - 3 prioritised write ports, 4 combinational read ports
  - optional parity bit per entry
- The top level holds the tag pipes, bank-enable decode and parity error register.

## Test plan
- **Reset check:** hold `rst_n`=0, then release; read all 32 registers across slices -> every read = 0, `rf_parity_err`=0.
- **AU write-back landing:**
  - Rotate `slice` 0,1,2,3,… with AU_WB_LAT=2. Assert `au_rc_vld` with `au_rc_sel`=5, `au_rc`=0xDEADBEEF in the cycle where `slice`=3.
  - Expect bank 1 r5 updated. Reading r5 when `slice`=1 -> 0xDEADBEEF; r5 of the other banks is still 0.
- **LS same-reg collision:** `ls_load_vld`, `au_rc_vld` and `ls_ptr_upd_vld` all target slice 2, r3 in one cycle, data 0x11 / 0x22 / 0x33 -> r3 of slice 2 reads 0x11.
- **LS distinct-reg writes:** `ls_load` → r1 = 0xA5A5A5A5 and `ls_ptr_upd` → r2 = 0x00001004 in the same cycle, slice 0 -> both stored.
- **Reset mid-operation:**
  - Pulse `rst_n` low for one cycle while `au_rc_vld` writes are in flight.
  - Expect all registers 0 and tags reset. The first strobe after release writes bank 0.
- **Parity (with `TAWAS_RF_PARITY_EN`):**
  - Force-flip the stored parity bit of slice 1 r7, then read r7 with `slice`=1.
  - Expect `rf_parity_err`=1 one cycle later with `rf_parity_err_slice`=1. Without the macro the output stays 0.
